// File: rtl/sprite_compositor.sv
// sprite_compositor: fixed-priority sprite/background merge onto a registered RGB
// stream, frame-wide pixel-exact player collision detection and post-crash flash.
module sprite_compositor #(
   parameter int N_OBJ        = 9,
   parameter int RGB_W        = 3,
   parameter int PLAYER_IDX   = 8,
   parameter int FLASH_FRAMES = 32,
   parameter int FLASH_PERIOD = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   video_on,
   input  logic                   frame_start,
   input  logic [N_OBJ-1:0]       on_objs,
   input  logic [N_OBJ*RGB_W-1:0] rgb_objs,
   input  logic [RGB_W-1:0]       rgb_bg,
   input  logic [N_OBJ-1:0]       hit_mask,
   output logic [RGB_W-1:0]       rgb,
   output logic                   collision_pulse,
   output logic [N_OBJ-1:0]       collision_mask,
   output logic                   crashed
);

   localparam logic [N_OBJ-1:0] PLAYER_BIT = {{(N_OBJ-1){1'b0}}, 1'b1} << PLAYER_IDX;
   localparam logic [7:0]       FLASH_LOAD = 8'(FLASH_FRAMES);
   localparam logic [7:0]       PHASE_LOAD = 8'(FLASH_PERIOD - 1);

   typedef enum logic [0:0] {
      ST_RUN   = 1'b0,
      ST_FLASH = 1'b1
   } state_t;

   // Highest set index wins; background when nothing is on.
   function automatic logic [RGB_W-1:0] pick_colour(
      input logic [N_OBJ-1:0]       on,
      input logic [N_OBJ*RGB_W-1:0] cols,
      input logic [RGB_W-1:0]       bg
   );
      logic [RGB_W-1:0] sel;
      sel = bg;
      for (int i = 0; i < N_OBJ; i++) begin
         if (on[i]) begin
            sel = cols[i*RGB_W +: RGB_W];
         end else begin
            sel = sel;
         end
      end
      return sel;
   endfunction

   logic                   vid_r;
   logic                   fs_r;
   logic [N_OBJ-1:0]       on_r;
   logic [N_OBJ*RGB_W-1:0] cols_r;
   logic [RGB_W-1:0]       bg_r;

   state_t                 state_r;
   state_t                 state_next_s;
   logic [7:0]             flash_r;
   logic [7:0]             flash_next_s;
   logic [7:0]             phase_r;
   logic [7:0]             phase_next_s;
   logic                   hidden_r;
   logic                   hidden_next_s;
   logic [N_OBJ-1:0]       acc_r;
   logic [N_OBJ-1:0]       acc_next_s;
   logic [N_OBJ-1:0]       mask_r;
   logic [N_OBJ-1:0]       mask_next_s;
   logic                   pulse_r;
   logic                   pulse_next_s;
   logic                   crashed_r;
   logic [RGB_W-1:0]       rgb_r;
   logic [RGB_W-1:0]       rgb_next_s;
   logic [N_OBJ-1:0]       eff_on_s;
   logic [N_OBJ-1:0]       hit_s;

   // S1: capture the raw pixel-stage inputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         vid_r  <= 1'b0;
         fs_r   <= 1'b0;
         on_r   <= {N_OBJ{1'b0}};
         cols_r <= {(N_OBJ*RGB_W){1'b0}};
         bg_r   <= {RGB_W{1'b0}};
      end else begin
         vid_r  <= video_on;
         fs_r   <= frame_start;
         on_r   <= on_objs;
         cols_r <= rgb_objs;
         bg_r   <= rgb_bg;
      end
   end

   // Colour selection and per-pixel hit; a hidden player still collides.
   always_comb begin
      eff_on_s   = hidden_r ? (on_r & ~PLAYER_BIT) : on_r;
      rgb_next_s = vid_r ? pick_colour(eff_on_s, cols_r, bg_r) : {RGB_W{1'b0}};
      if (vid_r && on_r[PLAYER_IDX]) begin
         hit_s = on_r & hit_mask & ~PLAYER_BIT;
      end else begin
         hit_s = {N_OBJ{1'b0}};
      end
      acc_next_s = fs_r ? hit_s : (acc_r | hit_s);
   end

   // RUN/FLASH next-state, flash counters and crash report.
   always_comb begin
      state_next_s  = state_r;
      flash_next_s  = flash_r;
      phase_next_s  = phase_r;
      hidden_next_s = hidden_r;
      mask_next_s   = mask_r;
      pulse_next_s  = 1'b0;
      case (state_r)
         ST_RUN: begin
            if (fs_r && (acc_r != {N_OBJ{1'b0}})) begin
               mask_next_s   = acc_r;
               pulse_next_s  = 1'b1;
               flash_next_s  = FLASH_LOAD;
               phase_next_s  = PHASE_LOAD;
               hidden_next_s = 1'b1;
               state_next_s  = ST_FLASH;
            end else begin
               state_next_s = ST_RUN;
            end
         end
         ST_FLASH: begin
            if (fs_r) begin
               flash_next_s = flash_r - 8'd1;
               if (flash_r == 8'd1) begin
                  hidden_next_s = 1'b0;
                  state_next_s  = ST_RUN;
               end else if (phase_r == 8'd0) begin
                  hidden_next_s = ~hidden_r;
                  phase_next_s  = PHASE_LOAD;
               end else begin
                  phase_next_s = phase_r - 8'd1;
               end
            end else begin
               state_next_s = ST_FLASH;
            end
         end
         default: begin
            state_next_s  = ST_RUN;
            hidden_next_s = 1'b0;
         end
      endcase
   end

   // S2 and control state registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r   <= ST_RUN;
         flash_r   <= 8'd0;
         phase_r   <= 8'd0;
         hidden_r  <= 1'b0;
         acc_r     <= {N_OBJ{1'b0}};
         mask_r    <= {N_OBJ{1'b0}};
         pulse_r   <= 1'b0;
         crashed_r <= 1'b0;
         rgb_r     <= {RGB_W{1'b0}};
      end else begin
         state_r   <= state_next_s;
         flash_r   <= flash_next_s;
         phase_r   <= phase_next_s;
         hidden_r  <= hidden_next_s;
         acc_r     <= acc_next_s;
         mask_r    <= mask_next_s;
         pulse_r   <= pulse_next_s;
         crashed_r <= (state_next_s == ST_FLASH);
         rgb_r     <= rgb_next_s;
      end
   end

   assign rgb             = rgb_r;
   assign collision_pulse = pulse_r;
   assign collision_mask  = mask_r;
   assign crashed         = crashed_r;

endmodule

// File: doc/sprite_compositor.md
# sprite_compositor

Parametrised pixel compositor for the VGA game top level. It merges N sprite layers plus the background into one registered RGB stream using fixed priority. It also detects pixel-exact player/obstacle overlap over a whole frame and runs a post-crash flash sequence on the player layer. It sits between the per-object graphic controllers and the VGA output pins, and replaces the combinational priority mux and position-based collision check.

## Interface
Parameters:
- N_OBJ, 9: number of sprite layers, excluding background; bit N_OBJ-1 has highest priority.
- RGB_W, 3: colour bits per pixel.
- PLAYER_IDX, 8: layer index of the player car.
- FLASH_FRAMES, 32: frames the FLASH state lasts; range 1..255.
- FLASH_PERIOD, 4: frames per visibility half-cycle during FLASH; range 1..FLASH_FRAMES.

Ports:
- clk, in, 1: pixel clock.
- reset, in, 1: asynchronous, active-low reset.
- video_on, in, 1: visible-area flag from vga_sync.
- frame_start, in, 1: one-cycle pulse on pixel (0,0) of each frame.
- on_objs, in, N_OBJ: per-layer pixel-hit flags.
- rgb_objs, in, N_OBJ*RGB_W: layer colours; layer i occupies bits [i*RGB_W +: RGB_W].
- rgb_bg, in, RGB_W: background colour, always drawn when no layer hits.
- hit_mask, in, N_OBJ: layers that count as obstacles. The PLAYER_IDX bit is ignored.
- rgb, out, RGB_W: composited pixel, forced to 0 outside video.
- collision_pulse, out, 1: one-cycle pulse when a crash is reported.
- collision_mask, out, N_OBJ: layers hit in the reported frame; held until the next report.
- crashed, out, 1: high while in the FLASH state.

## Operation
- Stage S1 registers video_on, frame_start, on_objs, rgb_objs and rgb_bg.
- Stage S2 drives the registered outputs from S1.
- Priority: the highest set index in the effective on vector wins. If no bit is set, rgb_bg is used.
- Effective on vector: on_objs with the PLAYER_IDX bit cleared when player_hidden=1.
- rgb output register is loaded with 0 when S1 video_on=0.
- Per-pixel hit: hit = {N_OBJ{on_objs[PLAYER_IDX]}} & on_objs & hit_mask, with the PLAYER_IDX bit forced to 0. Raw on_objs is used, so a hidden player still collides.
- The hit is only counted while S1 video_on=1.
- Accumulator acc (N_OBJ bits) ORs in hit every cycle.
- On S1 frame_start, acc is loaded with the current pixel's hit, not cleared to 0, so the first pixel of a frame is kept. The old acc value is evaluated as the completed frame.
- FSM states: RUN and FLASH.
  - RUN: on S1 frame_start with old acc≠0, set collision_mask←old acc and pulse collision_pulse. Load flash_cnt←FLASH_FRAMES and phase_cnt←FLASH_PERIOD-1, set player_hidden←1, and go to FLASH.
  - FLASH: a non-zero acc is discarded; no pulse and no mask update. Each S1 frame_start decrements flash_cnt.
  - FLASH phase: phase_cnt counts down each frame. When it reaches 0, player_hidden toggles and phase_cnt reloads FLASH_PERIOD-1.
  - FLASH exit: when flash_cnt decrements from 1 to 0, go to RUN and set player_hidden←0. Collisions in the final FLASH frame are not reported.
- crashed = (state==FLASH), registered.
- Counter widths: flash_cnt and phase_cnt are both 8 bits.

## Timing
- Reset values: rgb=0, collision_pulse=0, collision_mask=0, crashed=0. Internally, state=RUN, acc=0, player_hidden=0, and both counters are 0. frame_start is ignored until the first S1 capture after reset release.
- rgb latency: 2 clocks from inputs to output (S1, then S2).
- collision_pulse and the crashed rise: both occur on the clock edge after S1 captures frame_start, i.e. 2 clocks after the frame_start input.
- collision_pulse is exactly 1 cycle wide, and at most one pulse occurs per frame.
- Reset asserted mid-frame or mid-FLASH: everything returns to reset values immediately (asynchronous). The next frame starts in RUN with acc empty.
- frame_start held high for several cycles: each high cycle is treated as a frame boundary. This is legal but only single-cycle pulses are supported in use.

## Test plan
- Priority: on_objs=9'b1_0000_0010 with layer 8=3'b001 and layer 1=3'b110, video_on=1 → rgb=3'b001 two clocks later. Then on_objs=0 and rgb_bg=3'b010 → rgb=3'b010. Then video_on=0 → rgb=0.
- Overlap with mask: one frame with player and layer 3 overlapping for 5 pixels, hit_mask=9'h1FF → at the next frame_start, collision_pulse high for 1 cycle at +2 clocks, collision_mask=9'h008, crashed=1. Repeat with hit_mask=9'h000 → no pulse.
- Flash sequence: after a crash with FLASH_FRAMES=32 and FLASH_PERIOD=4, drive player-only pixels → player hidden in frames 1–4, visible in 5–8, and so on. crashed falls at the 32nd frame_start, and the player stays visible afterwards.
- Suppression during FLASH: overlap in every FLASH frame → no further pulse and collision_mask unchanged. An overlap in the first RUN frame after FLASH → pulse at the following frame_start.
- Boundary pixel: overlap only on the same cycle as frame_start → no pulse at that boundary; pulse at the next frame_start.
- Reset: drive reset low during FLASH with flash_cnt=10 → crashed=0, rgb=0 and collision_mask=0 immediately. After release, an overlap frame produces a fresh pulse.
